// File: rtl/fifo_arb_pkg.sv
// Shared state encoding, parameter defaults and index helper for the FIFO write arbiter.
// Latency: none, constants and a pure function only.
// Backpressure: not applicable.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF      = 4;
  localparam int DSIZE_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 8;

  // Requester index plus one, wrapping at n (round-robin successor).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit at start, start+1, ... wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Candidate index for each search position, already wrapped.
  logic [IW-1:0] cand [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_cand
    assign cand[k] = IW'((int'(start) + k) % NREQ);
  end

  // Take the first candidate that is requesting; later positions lose.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting up to MAX_BURST words per requester into one FIFO write port.
// Latency: first ack one cycle after req from idle; acks/winc/wdata are combinational in GRANT.
// Backpressure: I_wfull holds the grant and freezes the burst count; no ack or winc while full.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DSIZE     = DSIZE_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic [NREQ-1:0]          I_req,
  input  logic [NREQ*DSIZE-1:0]    I_data,
  output logic [NREQ-1:0]          O_ack,
  output logic                     O_winc,
  output logic [DSIZE-1:0]         O_wdata,
  input  logic                     I_wfull,
  output logic                     O_gnt_vld,
  output logic [$clog2(NREQ)-1:0]  O_gnt_id
);

  localparam int IW = $clog2(NREQ);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IW-1:0]    nxt_id;
  logic [IW-1:0]    pick_start;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             granted;
  logic             req_gnt;
  logic             xfer;
  logic             burst_end;
  logic             rel;

  // Reset masks the grant immediately so nothing is acked in the reset cycle.
  assign granted    = (state_q == GRANT) && !I_rst;
  assign req_gnt    = I_req[gnt_q];
  assign xfer       = granted && req_gnt && !I_wfull;
  assign burst_end  = (cnt_q == CNT_W'(MAX_BURST - 1));
  assign rel        = granted && ((xfer && burst_end) || !req_gnt);
  assign nxt_id     = IW'(wrap_inc(int'(gnt_q), NREQ));

  // One search shared by both paths: from ptr when idle, from the successor on release,
  // so the releasing requester is considered last.
  assign pick_start = (state_q == GRANT) ? nxt_id : ptr_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req   (I_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Write-side outputs follow the granted requester with no register stage.
  always_comb begin
    O_ack        = '0;
    O_ack[gnt_q] = xfer;
    O_winc       = xfer;
    O_wdata      = granted ? I_data[int'(gnt_q)*DSIZE +: DSIZE] : '0;
    O_gnt_vld    = granted;
    O_gnt_id     = I_rst ? '0 : gnt_q;
  end

  // Next-state: arbitrate from idle, count words, release and re-arbitrate in the same cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rel) begin
          ptr_d = nxt_id;
          cnt_d = '0;
          if (pick_found) begin
            gnt_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset back to idle, search restarting at requester 0.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: directed grant scenarios plus random req/full traffic.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Each requester holds its word until acked; acked words are matched against a per-requester queue.
module tb_fifo_wr_arb;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                    clk = 1'b0;
  logic                    I_rst;
  logic [NREQ-1:0]         I_req;
  logic [NREQ*DSIZE-1:0]   I_data;
  logic [NREQ-1:0]         O_ack;
  logic                    O_winc;
  logic [DSIZE-1:0]        O_wdata;
  logic                    I_wfull;
  logic                    O_gnt_vld;
  logic [1:0]              O_gnt_id;

  fifo_wr_arb #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .I_clk     (clk),
    .I_rst     (I_rst),
    .I_req     (I_req),
    .I_data    (I_data),
    .O_ack     (O_ack),
    .O_winc    (O_winc),
    .O_wdata   (O_wdata),
    .I_wfull   (I_wfull),
    .O_gnt_vld (O_gnt_vld),
    .O_gnt_id  (O_gnt_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Bench-side requester model and scoreboard.
  int               rem      [NREQ];
  bit               hold     [NREQ];
  bit               pushed   [NREQ];
  int               acked    [NREQ];
  logic [DSIZE-1:0] cur_word [NREQ];
  logic [DSIZE-1:0] exp_q    [NREQ][$];
  int               wlog_id[$];
  int               wlog_cyc[$];
  bit               rst_v;
  bit               full_v;
  int               cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < NREQ; i++) begin
      rem[i]      = 0;
      hold[i]     = 1'b0;
      pushed[i]   = 1'b0;
      acked[i]    = 0;
      cur_word[i] = DSIZE'($urandom);
      exp_q[i].delete();
    end
    wlog_id.delete();
    wlog_cyc.delete();
    full_v = 1'b0;
  endtask

  // One clock: drive requesters, then check outputs and advance the model on acks.
  task automatic step();
    logic [NREQ-1:0] req_v;
    int id;
    @(posedge clk);
    #1;
    I_rst   = rst_v;
    I_wfull = full_v;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = (rem[i] != 0) && !hold[i];
      I_data[i*DSIZE +: DSIZE] = cur_word[i];
      if (req_v[i] && !pushed[i]) begin
        exp_q[i].push_back(cur_word[i]);
        pushed[i] = 1'b1;
      end
    end
    I_req = req_v;
    @(negedge clk);
    cyc++;
    if (I_wfull) chk("winc_while_full", O_winc, 0);
    if (O_gnt_vld) begin
      chk("wdata_granted", O_wdata, cur_word[O_gnt_id]);
    end else begin
      chk("idle_wdata", O_wdata, 0);
      chk("idle_ack", O_ack, 0);
      chk("idle_winc", O_winc, 0);
    end
    if (O_winc || (O_ack != 0)) begin
      chk("one_ack", $countones(O_ack), 1);
      chk("ack_without_req", O_ack & ~I_req, 0);
      chk("winc_eq_ack", O_winc, 1);
      chk("ack_is_granted", O_ack, 1 << O_gnt_id);
      id = 0;
      for (int i = 0; i < NREQ; i++) if (O_ack[i]) id = i;
      if (exp_q[id].size() == 0) begin
        chk("sb_word_available", exp_q[id].size(), 1);
      end else begin
        chk("sb_wdata", O_wdata, exp_q[id].pop_front());
      end
      wlog_id.push_back(id);
      wlog_cyc.push_back(cyc);
      acked[id]++;
      rem[id]--;
      pushed[id]   = 1'b0;
      cur_word[id] = DSIZE'($urandom);
    end
  endtask

  task automatic do_reset();
    clr_model();
    rst_v = 1'b1;
    step();
    chk("rst_gnt_vld", O_gnt_vld, 0);
    chk("rst_gnt_id", O_gnt_id, 0);
    rst_v = 1'b0;
  endtask

  task automatic wait_acks(input int id, input int n, input int budget);
    for (int b = 0; b < budget && acked[id] < n; b++) step();
  endtask

  int c0;
  int nlog;

  initial begin
    I_rst   = 1'b1;
    I_req   = '0;
    I_data  = '0;
    I_wfull = 1'b0;
    rst_v   = 1'b0;
    cyc     = 0;

    // Single requester, six words: immediate self re-grant at burst end, no bubble.
    do_reset();
    step();
    chk("s1_idle_after_rst", O_gnt_vld, 0);
    rem[0] = 6;
    step();
    c0 = cyc;
    chk("s1_no_ack_on_req", O_ack, 0);
    wait_acks(0, 6, 20);
    chk("s1_words", acked[0], 6);
    for (int k = 0; k < 6 && k < wlog_cyc.size(); k++)
      chk($sformatf("s1_ack_cycle%0d", k), wlog_cyc[k] - c0, k + 1);
    step();
    step();
    chk("s1_back_to_idle", O_gnt_vld, 0);

    // All four requesting: bursts of four in order 0,1,2,3,0 back to back.
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 100;
    for (int b = 0; b < 40 && wlog_id.size() < 20; b++) step();
    chk("s2_log_len", (wlog_id.size() >= 20), 1);
    for (int k = 0; k < 20 && k < wlog_id.size(); k++) begin
      chk($sformatf("s2_id%0d", k), wlog_id[k], (k / 4) % 4);
      if (k > 0) chk($sformatf("s2_gap%0d", k), wlog_cyc[k] - wlog_cyc[0], k);
    end

    // Requester 2 stalled by full mid-burst: grant held, count frozen, four words in total.
    do_reset();
    rem[2] = 6;
    rem[3] = 2;
    wait_acks(2, 2, 20);
    chk("s3_pre_words", acked[2], 2);
    full_v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s3_stall_winc", O_winc, 0);
      chk("s3_stall_ack", O_ack, 0);
      chk("s3_stall_gnt", {O_gnt_vld, O_gnt_id}, {1'b1, 2'd2});
    end
    full_v = 1'b0;
    for (int b = 0; b < 30 && wlog_id.size() < 8; b++) step();
    nlog = wlog_id.size();
    chk("s3_total", nlog, 8);
    for (int k = 0; k < 5 && k < nlog; k++)
      chk($sformatf("s3_id%0d", k), wlog_id[k], (k < 4) ? 2 : 3);
    for (int i = 0; i < NREQ; i++) chk("s3_sb_empty", exp_q[i].size(), 0);

    // Requester 1 drops req after two words while 3 is waiting.
    do_reset();
    rem[1] = 10;
    rem[3] = 10;
    wait_acks(1, 2, 20);
    chk("s4_pre_words", acked[1], 2);
    hold[1] = 1'b1;
    step();
    chk("s4_drop_ack", O_ack, 0);
    chk("s4_drop_gnt", O_gnt_id, 1);
    step();
    chk("s4_next_vld", O_gnt_vld, 1);
    chk("s4_next_id", O_gnt_id, 3);
    chk("s4_next_ack", O_ack, 4'b1000);

    // Reset pulse in the middle of requester 3's burst, requests 1010 kept up.
    do_reset();
    rem[1] = 10;
    rem[3] = 10;
    wait_acks(3, 1, 30);
    chk("s5_pre_words", acked[3], 1);
    nlog  = wlog_id.size();
    rst_v = 1'b1;
    step();
    chk("s5_rst_ack", O_ack, 0);
    chk("s5_rst_winc", O_winc, 0);
    chk("s5_rst_vld", O_gnt_vld, 0);
    chk("s5_rst_wdata", O_wdata, 0);
    rst_v = 1'b0;
    step();
    chk("s5_post_vld", O_gnt_vld, 0);
    chk("s5_post_ack", O_ack, 0);
    chk("s5_post_winc", O_winc, 0);
    step();
    chk("s5_regrant_vld", O_gnt_vld, 1);
    chk("s5_regrant_id", O_gnt_id, 1);
    chk("s5_no_extra_ack", wlog_id.size(), nlog + 1);

    // Random req drops and full, then drain: every word written exactly once, in order.
    do_reset();
    for (int i = 0; i < NREQ; i++) rem[i] = 1500;
    for (int c = 0; c < 8000; c++) begin
      for (int i = 0; i < NREQ; i++) hold[i] = ($urandom_range(0, 7) == 0);
      full_v = ($urandom_range(0, 3) == 0);
      step();
    end
    for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
    full_v = 1'b0;
    for (int b = 0; b < 12000 && (rem[0] + rem[1] + rem[2] + rem[3]) != 0; b++) step();
    for (int i = 0; i < NREQ; i++) begin
      chk($sformatf("s6_acked%0d", i), acked[i], 1500);
      chk($sformatf("s6_sb_left%0d", i), exp_q[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
